// File: rtl/wallace_mult_pipe_if.sv
// Operand/product handshake bundle for wallace_mult_pipe.
// The multiplier takes the slave side; the operand source and product consumer take the master side.
interface wallace_mult_pipe_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sgn;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               p_sgn;

    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, p, p_sgn
    );

    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, p, p_sgn
    );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Three-stage elastic Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, per-transaction signed/unsigned.
// S1 holds operands, S2 the carry-save pair after reduction, S3 the final product.
module wallace_mult_pipe #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    wallace_mult_pipe_if.slave bus
);
    localparam int PW   = 2 * WIDTH;
    localparam int MD   = WIDTH + 4;
    localparam int NLVL = 12;

    logic             v1, v2, v3;
    logic             rdy1, rdy2, rdy3;
    logic [WIDTH-1:0] a1, b1;
    logic             s1, s2, s3;
    logic [PW-1:0]    row0, row1;
    logic [PW-1:0]    r0_q, r1_q;
    logic [PW-1:0]    p_q;

    // A stage may load whenever its contents move on or it is empty, so bubbles collapse.
    assign rdy3 = !v3 || bus.out_ready;
    assign rdy2 = !v2 || rdy3;
    assign rdy1 = !v1 || rdy2;

    assign bus.in_ready  = rdy1;
    assign bus.out_valid = v3;
    assign bus.p         = p_q;
    assign bus.p_sgn     = s3;

    // Column heights depend only on WIDTH, never on data, so the loops unroll into a fixed adder tree.
    always_comb begin : reduce
        logic cur [PW][MD];
        logic nxt [PW][MD];
        int   hc  [PW];
        int   hn  [PW];
        int   hmax;
        logic x, y, z;

        // NOTE: every combinational output and scratch value gets a default first, so no latch is inferred.
        row0 = '0;
        row1 = '0;
        hmax = 0;
        x    = 1'b0;
        y    = 1'b0;
        z    = 1'b0;
        for (int c = 0; c < PW; c++) begin
            hc[c] = 0;
            hn[c] = 0;
            for (int r = 0; r < MD; r++) begin
                cur[c][r] = 1'b0;
                nxt[c][r] = 1'b0;
            end
        end

        // Baugh-Wooley: signed mode inverts the cross terms that touch exactly one operand MSB.
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                x = a1[i] & b1[j];
                if (s1 && ((i == WIDTH - 1) != (j == WIDTH - 1)))
                    x = ~x;
                cur[i+j][hc[i+j]] = x;
                hc[i+j]++;
            end
        end
        cur[WIDTH][hc[WIDTH]] = s1;
        hc[WIDTH]++;
        cur[PW-1][hc[PW-1]] = s1;
        hc[PW-1]++;

        for (int lv = 0; lv < NLVL; lv++) begin
            hmax = 0;
            for (int c = 0; c < PW; c++)
                if (hc[c] > hmax) hmax = hc[c];
            if (hmax > 2) begin
                for (int c = 0; c < PW; c++) begin
                    hn[c] = 0;
                    for (int r = 0; r < MD; r++) nxt[c][r] = 1'b0;
                end
                for (int c = 0; c < PW; c++) begin
                    for (int r = 0; r <= WIDTH; r += 3) begin
                        if (r + 2 < hc[c]) begin
                            x = cur[c][r];
                            y = cur[c][r+1];
                            z = cur[c][r+2];
                            nxt[c][hn[c]] = x ^ y ^ z;
                            hn[c]++;
                            if (c + 1 < PW) begin
                                nxt[c+1][hn[c+1]] = (x & y) | (x & z) | (y & z);
                                hn[c+1]++;
                            end
                        end else if (r + 1 < hc[c]) begin
                            x = cur[c][r];
                            y = cur[c][r+1];
                            nxt[c][hn[c]] = x ^ y;
                            hn[c]++;
                            if (c + 1 < PW) begin
                                nxt[c+1][hn[c+1]] = x & y;
                                hn[c+1]++;
                            end
                        end else if (r < hc[c]) begin
                            nxt[c][hn[c]] = cur[c][r];
                            hn[c]++;
                        end
                    end
                end
                cur = nxt;
                hc  = hn;
            end
        end

        for (int c = 0; c < PW; c++) begin
            if (hc[c] > 0) row0[c] = cur[c][0];
            if (hc[c] > 1) row1[c] = cur[c][1];
        end
    end

    // NOTE: state registers use non-blocking assignment so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared along with the valid bits so empty stages never hold X.
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            s1   <= 1'b0;
            r0_q <= '0;
            r1_q <= '0;
            s2   <= 1'b0;
            p_q  <= '0;
            s3   <= 1'b0;
        end else begin
            if (rdy1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    a1 <= bus.a;
                    b1 <= bus.b;
                    s1 <= bus.sgn;
                end
            end
            if (rdy2) begin
                v2 <= v1;
                if (v1) begin
                    r0_q <= row0;
                    r1_q <= row1;
                    s2   <= s1;
                end
            end
            if (rdy3) begin
                v3 <= v2;
                if (v2) begin
                    p_q <= r0_q + r1_q;
                    s3  <= s2;
                end
            end
        end
    end
endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench: directed WIDTH=8 corners and handshake sequences, plus random sweeps at 4/13/32.
module tb_wallace_mult_pipe;
    localparam int NRAND = 10000;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rrst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp    = 0;
    int n_bad    = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- WIDTH=8 directed instance ----------------
    wallace_mult_pipe_if #(.WIDTH(8)) m_if ();
    wallace_mult_pipe #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(m_if));

    typedef struct {
        logic [15:0] p;
        logic        s;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e;
    vec_t        vt[6];
    int          cyc = 0;
    logic        chk_lat = 1'b0;
    int          emits, first_emit, last_emit, accepts, acc0;
    logic [15:0] cur_p;
    logic        cur_s;
    logic        held = 1'b0;
    logic [15:0] held_p;
    logic        held_s;

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint ea, eb, pr;
        ea = s ? longint'($signed(a)) : longint'(a);
        eb = s ? longint'($signed(b)) : longint'(b);
        pr = ea * eb;
        return pr[15:0];
    endfunction

    task automatic tick();
        #1;
        if (held) begin
            check("stall_hold_p", m_if.p, held_p);
            check("stall_hold_sgn", m_if.p_sgn, held_s);
        end
        if (m_if.out_valid && m_if.out_ready) begin
            check("pending_at_emit", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("p", m_if.p, e.p);
                check("p_sgn", m_if.p_sgn, e.s);
                if (chk_lat) check("latency", cyc - e.cyc, 3);
                emits++;
                if (first_emit < 0) first_emit = cyc;
                last_emit = cyc;
            end
        end
        if (m_if.in_valid && m_if.in_ready && !rst) begin
            exp_q.push_back('{cur_p, cur_s, cyc});
            accepts++;
        end
        held   = m_if.out_valid && !m_if.out_ready && !rst;
        held_p = m_if.p;
        held_s = m_if.p_sgn;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] pe);
        m_if.in_valid = 1'b1;
        m_if.a        = a;
        m_if.b        = b;
        m_if.sgn      = s;
        cur_p         = pe;
        cur_s         = s;
        tick();
    endtask

    task automatic drive_model(input logic s);
        logic [7:0] a, b;
        a = 8'($urandom());
        b = 8'($urandom());
        drive(a, b, s, model8(a, b, s));
    endtask

    task automatic drain();
        m_if.in_valid  = 1'b0;
        m_if.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
        tick();
        tick();
    endtask

    initial begin : main
        m_if.in_valid  = 1'b0;
        m_if.a         = '0;
        m_if.b         = '0;
        m_if.sgn       = 1'b0;
        m_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", m_if.out_valid, 0);
        check("reset_p", m_if.p, 0);
        check("reset_p_sgn", m_if.p_sgn, 0);
        rst  = 1'b0;
        rrst = 1'b0;
        emits = 0; first_emit = -1; last_emit = 0; accepts = 0;

        // Unsigned and signed corners, back to back, no backpressure.
        vt[0] = '{8'd255, 8'd255, 1'b0, 16'hFE01};
        vt[1] = '{8'd0,   8'd200, 1'b0, 16'h0000};
        vt[2] = '{8'd1,   8'd173, 1'b0, 16'h00AD};
        vt[3] = '{8'h80,  8'h80,  1'b1, 16'h4000};
        vt[4] = '{8'hFF,  8'h01,  1'b1, 16'hFFFF};
        vt[5] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
        chk_lat = 1'b1;
        for (int i = 0; i < 6; i++) drive(vt[i].a, vt[i].b, vt[i].s, vt[i].p);
        drain();

        // Ten consecutive mixed-mode transactions emerge on consecutive cycles.
        emits = 0; first_emit = -1; acc0 = cyc;
        for (int i = 0; i < 10; i++) drive_model(1'($urandom_range(1)));
        drain();
        check("b2b_count", emits, 10);
        check("b2b_spacing", last_emit - first_emit, 9);
        check("b2b_first_latency", first_emit - acc0, 3);
        chk_lat = 1'b0;

        // Backpressure: pipeline fills with exactly three, then releases in order.
        m_if.out_ready = 1'b0;
        accepts = 0;
        for (int i = 0; i < 6; i++) drive_model(1'($urandom_range(1)));
        m_if.in_valid = 1'b0;
        check("bp_accepts", accepts, 3);
        check("bp_full_in_ready", m_if.in_ready, 0);
        m_if.out_ready = 1'b1;
        #1;
        check("bp_in_ready_rise", m_if.in_ready, 1);
        emits = 0;
        for (int i = 0; i < 3; i++) tick();
        check("bp_release_count", emits, 3);
        drain();

        // Reset with two transactions in flight.
        drive_model(1'b0);
        drive_model(1'b1);
        m_if.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        held = 1'b0;
        m_if.out_ready = 1'b0;
        #1;
        check("rst_mid_out_valid", m_if.out_valid, 0);
        check("rst_mid_p", m_if.p, 0);
        check("rst_mid_in_ready", m_if.in_ready, 1);
        m_if.out_ready = 1'b1;
        emits = 0;
        drive(8'd3, 8'd5, 1'b0, 16'd15);
        drain();
        check("rst_new_emits", emits, 1);

        for (int i = 0; i < 70000 && done_cnt < 3; i++) @(posedge clk);
        check("sweeps_done", done_cnt, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // ---------------- Random sweeps at other widths ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 13 : 32);

        wallace_mult_pipe_if #(.WIDTH(W)) sif ();
        wallace_mult_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rrst), .bus(sif));

        logic [2*W-1:0] qp[$];
        logic           qs[$];

        initial begin : run
            int             sent, got, budget;
            logic [W-1:0]   ra, rb;
            logic           rs;
            longint         ea, eb;
            logic [63:0]    prod;
            sif.in_valid  = 1'b0;
            sif.a         = '0;
            sif.b         = '0;
            sif.sgn       = 1'b0;
            sif.out_ready = 1'b0;
            sent = 0; got = 0; budget = 0;
            wait (!rrst);
            @(posedge clk);
            #1;
            while (got < NRAND && budget < 60000) begin
                ra = W'($urandom());
                rb = W'($urandom());
                rs = 1'($urandom_range(1));
                sif.in_valid  = (sent < NRAND) && ($urandom_range(3) != 0);
                sif.a         = ra;
                sif.b         = rb;
                sif.sgn       = rs;
                sif.out_ready = ($urandom_range(3) != 0);
                #1;
                if (sif.out_valid && sif.out_ready) begin
                    check($sformatf("w%0d_pending", W), qp.size() > 0, 1);
                    if (qp.size() > 0) begin
                        check($sformatf("w%0d_p", W), sif.p, qp.pop_front());
                        check($sformatf("w%0d_sgn", W), sif.p_sgn, qs.pop_front());
                    end
                    got++;
                end
                if (sif.in_valid && sif.in_ready) begin
                    ea = rs ? longint'($signed(ra)) : longint'(ra);
                    eb = rs ? longint'($signed(rb)) : longint'(rb);
                    prod = ea * eb;
                    qp.push_back(prod[2*W-1:0]);
                    qs.push_back(rs);
                    sent++;
                end
                @(posedge clk);
                #1;
                budget++;
            end
            check($sformatf("w%0d_received", W), got, NRAND);
            check($sformatf("w%0d_leftover", W), qp.size(), 0);
            sif.in_valid  = 1'b0;
            sif.out_ready = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check($sformatf("w%0d_idle_out_valid", W), sif.out_valid, 0);
            done_cnt++;
        end
    end
endmodule
